scheduler_ctrl: RTL and testbench
=================================

Name: scheduler_ctrl

Overview:
Sequencing controller in front of the 16-tick x 256-axon scheduler SRAM.
- Router side: accepts delayed spike events, buffers them, and turns each into a single-bit SRAM write at tick (current_tick + delay) mod 16.
- Token-controller side: on each tick pulse, reads the current tick row, delivers it as an axon vector, clears the row, then advances current_tick.
- Only one SRAM operation is ever in flight, so SRAM conflict errors cannot occur.

Parameters:
FIFO_DEPTH, 8, spike buffer entries (power of 2, >=2)
TICKS, 16, scheduler rows (fixed by SRAM; tick index 4 bits)
AXONS, 256, bits per row (axon index 8 bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
spike_valid  in  1  router spike offered
spike_ready  out  1  spike accepted when valid&ready
spike_delay  in  4  delivery delay in ticks, legal 1..15
spike_axon  in  8  target axon
tick_pulse  in  1  one-cycle global tick strobe
axon_vec  out  256  row read for the tick being served
axon_valid  out  1  one-cycle strobe, axon_vec valid
tick_done  out  1  one-cycle strobe, row cleared and tick advanced
current_tick  out  4  tick row served by next tick_pulse
sram_write_request / sram_read_request / sram_clear_request  out  1 each  SRAM op requests
sram_write_tick / sram_read_tick / sram_clear_tick  out  4 each  SRAM row addresses
sram_write_axon  out  8  SRAM bit address
sram_read_data  in  256  SRAM row data
sram_ready  in  1  SRAM idle
sram_error  in  1  SRAM conflict/error flag
bad_spike  out  1  sticky: a delay-0 spike was dropped
tick_overrun  out  1  sticky: tick_pulse arrived while a tick was still pending
ctrl_error  out  1  sticky: SRAM error seen, controller halted

Behaviour:
- Reset: registered on clk when rst=1. Result: FIFO empty, current_tick=0, all requests/addresses=0, axon_vec=0, all strobes and sticky flags=0, state IDLE.
- Reset mid-operation aborts silently. The SRAM shares the same rst.
- Spike accept: spike_ready = !fifo_full & !tick_pending & state!=ERROR.
  - On handshake, target = (current_tick + spike_delay) mod 16, 4-bit wrap. Enqueue {target, axon}.
  - delay=0: handshake completes, nothing is enqueued, bad_spike set.
- tick_pulse sets tick_pending.
  - If tick_pending is already 1, the pulse is dropped and tick_overrun set.
- SRAM op protocol:
  - A request is asserted for exactly one cycle, in the ISSUE state, only when sram_ready=1.
  - The address is held stable from ISSUE until WAIT sees sram_ready=1 again.
  - WAIT exits on sram_ready=1. Each op takes 5 cycles from an IDLE decision to the next IDLE.
- FSM: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CLR_ISSUE, CLR_WAIT, ERROR.
  - IDLE: if the FIFO is non-empty, pop and go to WR_ISSUE. Otherwise, if tick_pending, go to RD_ISSUE. Pending spikes always drain before the tick read; acceptance is frozen while tick_pending=1, so targets are never stale.
  - WR_WAIT -> IDLE.
  - RD_WAIT: capture sram_read_data into axon_vec, go to CLR_ISSUE. axon_valid is high during the CLR_ISSUE cycle.
  - CLR_ISSUE clears row current_tick.
  - CLR_WAIT -> IDLE: current_tick increments (mod 16), tick_pending clears, and tick_done pulses in the next cycle.
- Latency: idle controller, empty FIFO, tick_pulse high in cycle t:
  - sram_read_request in t+2
  - axon_valid in t+6
  - tick_done and the new current_tick visible in t+10
- Wrap: current_tick 15 -> 0. Target 0xE + delay 3 = 0x1.
- Simultaneous spike handshake and tick_pulse in the same cycle: the spike is enqueued with the pre-advance current_tick.
- Duplicate spikes to the same bit are idempotent.
- sram_error=1 in any cycle forces ERROR:
  - all requests 0, spike_ready 0, ctrl_error 1
  - held until rst

Decomposition:
- Package scheduler_pkg: TICK_W=4, AXON_W=8, TICKS, AXONS, controller state enum, and the FIFO entry typedef {tick[3:0], axon[7:0]}.
- One sub-module: spike_fifo. Synchronous FIFO with full/empty and simultaneous push/pop allowed.

Test Plan:
1. Reset: assert rst 3 cycles -> spike_ready=1, current_tick=0, all requests/strobes/sticky flags 0, axon_vec=0.
2. Spike delay=3, axon=17 at current_tick=0, then 4 tick_pulses -> axon_vec zero for ticks 0-2, bit 17 only on the 4th. 16 more pulses -> row 3 is seen zero again (cleared).
3. Idle tick_pulse at cycle t -> sram_read_request at t+2, axon_valid at t+6, tick_done at t+10, current_tick 0->1. No write request ever overlaps another request.
4. 12 back-to-back spikes, FIFO_DEPTH=8 -> spike_ready drops after FIFO full. All 12 writes are issued with correct tick/axon. Backpressure ends as writes drain.
5. 3 spikes queued, then tick_pulse -> spike_ready=0 until tick_done, and all 3 write requests precede sram_read_request. current_tick=15 plus delay 2 -> write to tick 1.
6. Error paths:
   - delay=0 spike -> no write, bad_spike=1.
   - second tick_pulse before tick_done -> tick_overrun=1.
   - force sram_error -> ctrl_error=1, requests stop; cleared only by rst.

Source files
------------

// File: rtl/scheduler_pkg.sv
// Shared types for the scheduler SRAM sequencing controller: widths,
// controller FSM state encoding and the spike FIFO entry layout.
package scheduler_pkg;

  localparam int TICK_W = 4;
  localparam int AXON_W = 8;
  localparam int TICKS  = 16;
  localparam int AXONS  = 256;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    CLR_ISSUE,
    CLR_WAIT,
    ERROR
  } ctrl_state_e;

  typedef struct packed {
    logic [TICK_W-1:0] tick;
    logic [AXON_W-1:0] axon;
  } fifo_entry_t;

  // Delivery row; the 4-bit sum wraps naturally across the 16 rows.
  function automatic logic [TICK_W-1:0] target_tick(input logic [TICK_W-1:0] cur,
                                                     input logic [TICK_W-1:0] delay);
    return cur + delay;
  endfunction

endpackage

// File: rtl/scheduler_ctrl_if.sv
// Router spike handshake plus scheduler SRAM request bus. master = controller,
// slave = router/SRAM side.
// spike handshake: a spike transfers on every clk edge where spike_valid and
// spike_ready are both 1; spike_delay/spike_axon must be stable while valid=1.
interface scheduler_ctrl_if;
  import scheduler_pkg::*;

  logic                    spike_valid;
  logic                    spike_ready;
  logic [TICK_W-1:0]       spike_delay;
  logic [AXON_W-1:0]       spike_axon;

  logic                    sram_write_request;
  logic                    sram_read_request;
  logic                    sram_clear_request;
  logic [TICK_W-1:0]       sram_write_tick;
  logic [TICK_W-1:0]       sram_read_tick;
  logic [TICK_W-1:0]       sram_clear_tick;
  logic [AXON_W-1:0]       sram_write_axon;
  logic [AXONS-1:0]        sram_read_data;
  logic                    sram_ready;
  logic                    sram_error;

  modport master (
    input  spike_valid, spike_delay, spike_axon,
    output spike_ready,
    output sram_write_request, sram_read_request, sram_clear_request,
    output sram_write_tick, sram_read_tick, sram_clear_tick, sram_write_axon,
    input  sram_read_data, sram_ready, sram_error
  );

  modport slave (
    output spike_valid, spike_delay, spike_axon,
    input  spike_ready,
    input  sram_write_request, sram_read_request, sram_clear_request,
    input  sram_write_tick, sram_read_tick, sram_clear_tick, sram_write_axon,
    output sram_read_data, sram_ready, sram_error
  );
endinterface

// File: rtl/scheduler_ctrl_spike_fifo.sv
// Synchronous FIFO of pending spike writes; push and pop may coincide.
module spike_fifo
  import scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t pop_data,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/scheduler_ctrl.sv
// Sequences spike writes and per-tick read/clear of the scheduler SRAM,
// keeping exactly one SRAM operation in flight at a time.
module scheduler_ctrl
  import scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  scheduler_ctrl_if.master    bus,
  input  logic                tick_pulse,
  output logic [AXONS-1:0]    axon_vec,
  output logic                axon_valid,
  output logic                tick_done,
  output logic [TICK_W-1:0]   current_tick,
  output logic                bad_spike,
  output logic                tick_overrun,
  output logic                ctrl_error,
  output ctrl_state_e         dbg_state
);
  ctrl_state_e  state, next_state;
  logic         tick_pending;
  logic [TICK_W-1:0] wr_tick;
  logic [AXON_W-1:0] wr_axon;

  fifo_entry_t  fifo_in, fifo_out;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic         accept, tick_advance, row_captured;

  assign accept    = bus.spike_valid && bus.spike_ready;
  assign fifo_push = accept && (bus.spike_delay != '0);
  assign fifo_pop  = (state == IDLE) && !fifo_empty && !bus.sram_error;
  assign fifo_in   = '{tick: target_tick(current_tick, bus.spike_delay), axon: bus.spike_axon};

  assign tick_advance = (state == CLR_WAIT) && (next_state == IDLE);
  assign row_captured = (state == RD_WAIT) && (next_state == CLR_ISSUE);

  spike_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Spikes always drain before a pending tick is served.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!fifo_empty)       next_state = WR_ISSUE;
        else if (tick_pending) next_state = RD_ISSUE;
      end
      WR_ISSUE:  if (bus.sram_ready) next_state = WR_WAIT;
      WR_WAIT:   if (bus.sram_ready) next_state = IDLE;
      RD_ISSUE:  if (bus.sram_ready) next_state = RD_WAIT;
      RD_WAIT:   if (bus.sram_ready) next_state = CLR_ISSUE;
      CLR_ISSUE: if (bus.sram_ready) next_state = CLR_WAIT;
      CLR_WAIT:  if (bus.sram_ready) next_state = IDLE;
      ERROR:     next_state = ERROR;
      default:   next_state = ERROR;
    endcase
    if (bus.sram_error) next_state = ERROR;
  end

  always_comb begin
    bus.spike_ready        = !fifo_full && !tick_pending && (state != ERROR);
    bus.sram_write_request = (state == WR_ISSUE)  && bus.sram_ready;
    bus.sram_read_request  = (state == RD_ISSUE)  && bus.sram_ready;
    bus.sram_clear_request = (state == CLR_ISSUE) && bus.sram_ready;
    bus.sram_write_tick    = wr_tick;
    bus.sram_write_axon    = wr_axon;
    bus.sram_read_tick     = current_tick;
    bus.sram_clear_tick    = current_tick;
    ctrl_error             = (state == ERROR);
    dbg_state              = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_pending <= 1'b0;
      current_tick <= '0;
      axon_vec     <= '0;
      axon_valid   <= 1'b0;
      tick_done    <= 1'b0;
      bad_spike    <= 1'b0;
      tick_overrun <= 1'b0;
      wr_tick      <= '0;
      wr_axon      <= '0;
    end else begin
      axon_valid <= row_captured;
      tick_done  <= tick_advance;
      if (row_captured) axon_vec <= bus.sram_read_data;
      if (tick_advance) current_tick <= current_tick + 4'd1;
      if (tick_pulse && tick_pending) tick_overrun <= 1'b1;
      tick_pending <= (tick_pending && !tick_advance) || (tick_pulse && !tick_pending);
      if (accept && (bus.spike_delay == '0)) bad_spike <= 1'b1;
      if (fifo_pop) begin
        wr_tick <= fifo_out.tick;
        wr_axon <= fifo_out.axon;
      end
    end
  end
endmodule

// File: tb/tb_scheduler_ctrl.sv
// Directed bench for scheduler_ctrl with a behavioural SRAM and scoreboard queues.
module tb_scheduler_ctrl;
  import scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_pulse = 1'b0;
  logic err_inj = 1'b0;
  logic [AXONS-1:0]  axon_vec;
  logic              axon_valid, tick_done, bad_spike, tick_overrun, ctrl_error;
  logic [TICK_W-1:0] current_tick;
  ctrl_state_e       dbg_state;

  scheduler_ctrl_if bus ();

  scheduler_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tick_pulse   (tick_pulse),
    .axon_vec     (axon_vec),
    .axon_valid   (axon_valid),
    .tick_done    (tick_done),
    .current_tick (current_tick),
    .bad_spike    (bad_spike),
    .tick_overrun (tick_overrun),
    .ctrl_error   (ctrl_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural SRAM: busy for 2 cycles after any request ----------------
  logic [AXONS-1:0] sram_mem [TICKS];
  logic [AXONS-1:0] sram_rdata;
  logic [1:0]       sram_busy;

  assign bus.sram_ready     = (sram_busy == 2'd0);
  assign bus.sram_read_data = sram_rdata;
  assign bus.sram_error     = err_inj;

  always @(posedge clk) begin
    if (rst) begin
      sram_busy  <= 2'd0;
      sram_rdata <= '0;
      for (int i = 0; i < TICKS; i++) sram_mem[i] <= '0;
    end else begin
      if (sram_busy != 2'd0) sram_busy <= sram_busy - 2'd1;
      if (bus.sram_write_request || bus.sram_read_request || bus.sram_clear_request)
        sram_busy <= 2'd2;
      if (bus.sram_write_request) sram_mem[bus.sram_write_tick][bus.sram_write_axon] <= 1'b1;
      if (bus.sram_clear_request) sram_mem[bus.sram_clear_tick] <= '0;
      if (bus.sram_read_request)  sram_rdata <= sram_mem[bus.sram_read_tick];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [TICK_W+AXON_W-1:0] exp_wr_q [$];
  logic [AXONS-1:0]         exp_vec_q [$];
  logic [AXONS-1:0]         exp_mem [TICKS];
  logic [TICK_W-1:0]        model_tick = '0;
  bit                       err_mode = 1'b0;
  int                       stalls = 0;

  task automatic check(input string tag, input logic [AXONS-1:0] obs, input logic [AXONS-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    n_vec++;
    assert (cond) else begin
      n_fail++;
      $error("FAIL %s: observed false expected true", tag);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      int nreq;
      logic [TICK_W+AXON_W-1:0] e;
      nreq = int'(bus.sram_write_request) + int'(bus.sram_read_request) + int'(bus.sram_clear_request);
      if (nreq != 0) check("single_request", nreq, 1);
      if (err_mode) check("req_in_error", nreq, 0);
      if (bus.sram_write_request) begin
        check_true("unexpected_write", exp_wr_q.size() != 0);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check("write_tick", bus.sram_write_tick, e[TICK_W+AXON_W-1:AXON_W]);
          check("write_axon", bus.sram_write_axon, e[AXON_W-1:0]);
        end
      end
      if (bus.sram_read_request)  check("read_tick",  bus.sram_read_tick,  model_tick);
      if (bus.sram_clear_request) check("clear_tick", bus.sram_clear_tick, model_tick);
      if (axon_valid) begin
        check_true("unexpected_axon_valid", exp_vec_q.size() != 0);
        if (exp_vec_q.size() != 0) check("axon_vec", axon_vec, exp_vec_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_pulse = 1'b0;
    err_inj = 1'b0;
    bus.spike_valid = 1'b0;
    bus.spike_delay = '0;
    bus.spike_axon  = '0;
    exp_wr_q.delete();
    exp_vec_q.delete();
    for (int i = 0; i < TICKS; i++) exp_mem[i] = '0;
    model_tick = '0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic send_spike(input logic [TICK_W-1:0] delay, input logic [AXON_W-1:0] axon);
    logic [TICK_W-1:0] tgt;
    bit got;
    got = 1'b0;
    bus.spike_valid = 1'b1;
    bus.spike_delay = delay;
    bus.spike_axon  = axon;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.spike_ready) begin
        got = 1'b1;
        if (delay != '0) begin
          tgt = model_tick + delay;
          exp_wr_q.push_back({tgt, axon});
          exp_mem[tgt][axon] = 1'b1;
        end
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.spike_valid = 1'b0;
    check_true("spike_accept_timeout", got);
  endtask

  task automatic drain_writes();
    for (int k = 0; k < 1000 && exp_wr_q.size() != 0; k++) @(negedge clk);
    check("writes_drained", exp_wr_q.size(), 0);
    step(6);
  endtask

  task automatic do_tick(input bit check_lat);
    int rd_at, av_at, td_at;
    bit done;
    rd_at = -1; av_at = -1; td_at = -1; done = 1'b0;
    exp_vec_q.push_back(exp_mem[model_tick]);
    exp_mem[model_tick] = '0;
    tick_pulse = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (k == 1) check("ready_frozen", bus.spike_ready, 0);
      if (bus.sram_read_request && rd_at < 0) begin
        rd_at = k;
        check("writes_before_read", exp_wr_q.size(), 0);
      end
      if (axon_valid && av_at < 0) av_at = k;
      if (tick_done) begin
        td_at = k;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      tick_pulse = 1'b0;
    end
    check_true("tick_done_timeout", done);
    model_tick = model_tick + 4'd1;
    if (check_lat) begin
      check("lat_read_request", rd_at, 2);
      check("lat_axon_valid",   av_at, 6);
      check("lat_tick_done",    td_at, 10);
    end
    check("current_tick", current_tick, model_tick);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit done;
    logic [TICK_W-1:0] d;

    // 1. reset state
    do_reset();
    @(negedge clk);
    check("rst_spike_ready",   bus.spike_ready, 1);
    check("rst_current_tick",  current_tick, 0);
    check("rst_requests",      {bus.sram_write_request, bus.sram_read_request, bus.sram_clear_request}, 0);
    check("rst_addresses",     {bus.sram_write_tick, bus.sram_read_tick, bus.sram_clear_tick, bus.sram_write_axon}, 0);
    check("rst_strobes",       {axon_valid, tick_done}, 0);
    check("rst_sticky",        {bad_spike, tick_overrun, ctrl_error}, 0);
    check("rst_axon_vec",      axon_vec, 0);
    step(1);

    // 2+3. single spike, idle tick latency, row delivered then cleared
    send_spike(4'd3, 8'd17);
    drain_writes();
    do_tick(1'b1);
    for (int i = 0; i < 3; i++) do_tick(1'b0);
    for (int i = 0; i < 16; i++) do_tick(1'b0);

    // 4. 12 back-to-back spikes against an 8-deep FIFO
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      d = 4'($urandom_range(1, 15));
      send_spike(d, 8'($urandom_range(0, 255)));
    end
    check_true("backpressure_seen", stalls > 0);
    drain_writes();
    @(negedge clk);
    check("ready_after_drain", bus.spike_ready, 1);
    step(1);

    // 5. advance to tick 15, queue spikes, then tick: writes precede read, wrap 15+2 -> 1
    while (model_tick != 4'd15) do_tick(1'b0);
    send_spike(4'd2, 8'd200);
    send_spike(4'($urandom_range(1, 15)), 8'($urandom_range(0, 255)));
    send_spike(4'd2, 8'd201);
    do_tick(1'b0);
    check("wrapped_tick", current_tick, 0);
    do_tick(1'b0);
    do_tick(1'b0);

    // 6a. delay-0 spike is dropped and flagged
    send_spike(4'd0, 8'd5);
    step(10);
    @(negedge clk);
    check("bad_spike", bad_spike, 1);
    step(1);

    // 6b. second tick_pulse while pending is dropped and flagged
    exp_vec_q.push_back(exp_mem[model_tick]);
    exp_mem[model_tick] = '0;
    tick_pulse = 1'b1;
    step(1);
    tick_pulse = 1'b0;
    step(2);
    tick_pulse = 1'b1;
    step(1);
    tick_pulse = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (tick_done) done = 1'b1;
    end
    check_true("overrun_tick_done_timeout", done);
    model_tick = model_tick + 4'd1;
    step(15);
    @(negedge clk);
    check("tick_overrun", tick_overrun, 1);
    check("overrun_single_advance", current_tick, model_tick);
    check("overrun_no_extra_row", exp_vec_q.size(), 0);
    step(1);

    // 6c. SRAM error halts the controller until reset
    err_inj = 1'b1;
    step(1);
    err_inj = 1'b0;
    @(negedge clk);
    check("ctrl_error_set", ctrl_error, 1);
    check("error_ready_low", bus.spike_ready, 0);
    err_mode = 1'b1;
    step(1);
    tick_pulse = 1'b1;
    bus.spike_valid = 1'b1;
    bus.spike_delay = 4'd4;
    step(1);
    tick_pulse = 1'b0;
    step(20);
    bus.spike_valid = 1'b0;
    @(negedge clk);
    check("ctrl_error_held", ctrl_error, 1);
    err_mode = 1'b0;
    step(1);
    do_reset();
    @(negedge clk);
    check("ctrl_error_cleared", ctrl_error, 0);
    check("post_err_ready", bus.spike_ready, 1);
    step(1);
    do_tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
